// File: rtl/rx_frame_aligner.sv
// Byte-stream frame aligner for a transceiver RX path: hunts for SYNC_WORD,
// requests bit slides when none is found, and tracks lock on a fixed frame period.
module rx_frame_aligner #(
  parameter logic [7:0] SYNC_WORD  = 8'hBC,
  parameter int         FRAME_LEN  = 16,
  parameter int         LOCK_CNT   = 4,
  parameter int         LOSS_CNT   = 3,
  parameter int         SLIDE_WAIT = 32
) (
  input  logic       rx_clk,
  input  logic       reset,
  input  logic       reset_done,
  input  logic [7:0] rx_data,
  output logic       rx_slide,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       aligned,
  output logic [7:0] slide_count
);

  localparam int PW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int SW = $clog2(SLIDE_WAIT + 1);

  localparam logic [PW-1:0] POS_LAST  = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] POS_ZERO  = PW'(0);
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);
  localparam logic [MW-1:0] MATCH_ZRO = MW'(0);
  localparam logic [LW-1:0] MISS_MAX  = LW'(LOSS_CNT);
  localparam logic [LW-1:0] MISS_ZRO  = LW'(0);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SLIDE_WAIT);
  localparam logic [SW-1:0] SETTLE_Z  = SW'(0);
  localparam logic [SW-1:0] SETTLE_1  = SW'(1);

  localparam logic [2:0] WAIT_RST = 3'd0;
  localparam logic [2:0] SEARCH   = 3'd1;
  localparam logic [2:0] SLIDE    = 3'd2;
  localparam logic [2:0] SETTLE   = 3'd3;
  localparam logic [2:0] CHECK    = 3'd4;
  localparam logic [2:0] LOCKED   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [PW-1:0] win_q, win_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          slide_q, slide_d;
  logic [7:0]    dout_q, dout_d;
  logic          dv_q, dv_d;
  logic          fs_q, fs_d;
  logic          aligned_q, aligned_d;
  logic [7:0]    scnt_q, scnt_d;

  logic          is_sync_s;
  logic [PW-1:0] pos_nxt_s;
  logic          on_pos_s;

  assign is_sync_s = (rx_data == SYNC_WORD);
  assign pos_nxt_s = (pos_q == POS_LAST) ? POS_ZERO : (pos_q + 1'b1);
  assign on_pos_s  = (pos_nxt_s == POS_ZERO);

  // Next-state logic for the alignment FSM and its counters.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    win_d     = win_q;
    match_d   = match_q;
    miss_d    = miss_q;
    slide_d   = 1'b0;
    dout_d    = rx_data;
    dv_d      = 1'b0;
    fs_d      = 1'b0;
    aligned_d = aligned_q;
    scnt_d    = scnt_q;
    // The settle counter keeps running down even if reset_done drops, so
    // a WAIT_RST detour can never squeeze two slide pulses too close together.
    if (settle_q != SETTLE_Z) begin
      settle_d = settle_q - 1'b1;
    end else begin
      settle_d = settle_q;
    end

    if (!reset_done) begin
      state_d   = WAIT_RST;
      win_d     = POS_ZERO;
      pos_d     = POS_ZERO;
      match_d   = MATCH_ZRO;
      miss_d    = MISS_ZRO;
      aligned_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_RST: begin
          state_d = SEARCH;
          win_d   = POS_ZERO;
        end
        SEARCH: begin
          if (is_sync_s) begin
            state_d = CHECK;
            pos_d   = POS_ZERO;
            match_d = MATCH_ONE;
          end else if (win_q == POS_LAST) begin
            if (settle_q == SETTLE_Z) begin
              state_d = SLIDE;
              win_d   = POS_ZERO;
            end else begin
              state_d = SEARCH;
            end
          end else begin
            win_d = win_q + 1'b1;
          end
        end
        SLIDE: begin
          slide_d  = 1'b1;
          scnt_d   = scnt_q + 8'd1;
          settle_d = SETTLE_LD;
          state_d  = SETTLE;
        end
        SETTLE: begin
          if (settle_q <= SETTLE_1) begin
            state_d = SEARCH;
            win_d   = POS_ZERO;
          end else begin
            state_d = SETTLE;
          end
        end
        CHECK: begin
          pos_d = pos_nxt_s;
          if (on_pos_s) begin
            if (is_sync_s) begin
              if ((match_q + 1'b1) >= MATCH_MAX) begin
                match_d   = MATCH_MAX;
                miss_d    = MISS_ZRO;
                aligned_d = 1'b1;
                state_d   = LOCKED;
              end else begin
                match_d = match_q + 1'b1;
              end
            end else begin
              state_d = SEARCH;
              win_d   = POS_ZERO;
              match_d = MATCH_ZRO;
            end
          end else begin
            state_d = CHECK;
          end
        end
        LOCKED: begin
          dv_d  = 1'b1;
          pos_d = pos_nxt_s;
          if (on_pos_s) begin
            if (is_sync_s) begin
              miss_d = MISS_ZRO;
              fs_d   = 1'b1;
            end else if ((miss_q + 1'b1) >= MISS_MAX) begin
              miss_d    = MISS_MAX;
              match_d   = MATCH_ZRO;
              aligned_d = 1'b0;
              win_d     = POS_ZERO;
              state_d   = SEARCH;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d   = WAIT_RST;
          aligned_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q   <= WAIT_RST;
      pos_q     <= POS_ZERO;
      win_q     <= POS_ZERO;
      match_q   <= MATCH_ZRO;
      miss_q    <= MISS_ZRO;
      settle_q  <= SETTLE_Z;
      slide_q   <= 1'b0;
      dout_q    <= 8'h00;
      dv_q      <= 1'b0;
      fs_q      <= 1'b0;
      aligned_q <= 1'b0;
      scnt_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      win_q     <= win_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      settle_q  <= settle_d;
      slide_q   <= slide_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      fs_q      <= fs_d;
      aligned_q <= aligned_d;
      scnt_q    <= scnt_d;
    end
  end

  assign rx_slide    = slide_q;
  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign frame_start = fs_q;
  assign aligned     = aligned_q;
  assign slide_count = scnt_q;

endmodule

// File: tb/tb_rx_frame_aligner.sv
// Self-checking bench for rx_frame_aligner: vector table for lock/loss,
// hand sequences for reset_done drop, wrong period, slide spacing and reset.
module tb_rx_frame_aligner;

  logic       rx_clk = 1'b0;
  logic       reset, reset_done;
  logic [7:0] rx_data;
  logic       rx_slide, data_valid, frame_start, aligned;
  logic [7:0] data_out, slide_count;

  always #5 rx_clk = ~rx_clk;

  rx_frame_aligner dut (
    .rx_clk(rx_clk), .reset(reset), .reset_done(reset_done), .rx_data(rx_data),
    .rx_slide(rx_slide), .data_out(data_out), .data_valid(data_valid),
    .frame_start(frame_start), .aligned(aligned), .slide_count(slide_count)
  );

  typedef struct {
    logic [7:0] d;
    logic       al;
    logic       dv;
    logic       fs;
    logic       sl;
  } vec_t;

  vec_t       tbl [200];
  logic [7:0] dq [$];
  int  n_chk = 0, n_fail = 0;
  int  cyc_no = 0, n_pulse = 0, last_pulse = -1;
  bit  exact_gap = 1'b0;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc_no, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0b expected %0b", name, cyc_no, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc_no, act, exp);
    end
  endtask

  // One clock: drive at negedge, observe 1 ns after the rising edge.
  task automatic cyc(input logic rst, input logic rd, input logic [7:0] d);
    logic [7:0] e;
    @(negedge rx_clk);
    reset = rst; reset_done = rd; rx_data = d;
    dq.push_back(rst ? 8'h00 : d);
    @(posedge rx_clk);
    #1;
    cyc_no++;
    e = dq.pop_front();
    chk8("data_out", data_out, e);
    if (rst) begin
      n_pulse = 0;
      last_pulse = -1;
    end else if (rx_slide === 1'b1) begin
      n_pulse++;
      chk8("slide_count", slide_count, 8'(n_pulse));
      if (last_pulse >= 0) begin
        if (exact_gap) chk_int("slide_gap", cyc_no - last_pulse, 49);
        else chk1("slide_gap_min", (cyc_no - last_pulse) >= 33, 1'b1);
      end
      last_pulse = cyc_no;
    end
  endtask

  task automatic check_reset_outputs();
    chk1("rst_rx_slide", rx_slide, 1'b0);
    chk1("rst_aligned", aligned, 1'b0);
    chk1("rst_data_valid", data_valid, 1'b0);
    chk1("rst_frame_start", frame_start, 1'b0);
    chk8("rst_slide_count", slide_count, 8'h00);
  endtask

  // Four on-period syncs from SEARCH; lock must appear right after the 4th.
  task automatic lock_up();
    for (int k = 0; k <= 48; k++) begin
      cyc(1'b0, 1'b1, (k % 16 == 0) ? 8'hBC : 8'h20);
      if (k == 47) chk1("lock_early", aligned, 1'b0);
      if (k == 48) chk1("lock_on_4th", aligned, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; reset_done = 1'b0; rx_data = 8'h00;

    for (int k = 0; k < 200; k++) begin
      logic miss;
      miss = (k == 112) || (k == 128) || (k == 160) || (k == 176) || (k == 192);
      tbl[k].d  = (k % 16 == 0) ? (miss ? 8'h00 : 8'hBC) : 8'(16 + (k % 16));
      tbl[k].al = (k >= 48) && (k < 192);
      tbl[k].dv = (k >= 49) && (k <= 192);
      tbl[k].fs = (k == 64) || (k == 80) || (k == 96) || (k == 144);
      tbl[k].sl = 1'b0;
    end

    // Reset state, then lock, tolerated misses and loss of lock from the table.
    cyc(1'b1, 1'b1, 8'hBC);
    cyc(1'b1, 1'b1, 8'hBC);
    check_reset_outputs();
    cyc(1'b0, 1'b1, 8'h00);
    chk1("wait_rst_aligned", aligned, 1'b0);
    for (int i = 0; i < 200; i++) begin
      cyc(1'b0, 1'b1, tbl[i].d);
      chk1("tbl_aligned", aligned, tbl[i].al);
      chk1("tbl_data_valid", data_valid, tbl[i].dv);
      chk1("tbl_frame_start", frame_start, tbl[i].fs);
      chk1("tbl_rx_slide", rx_slide, tbl[i].sl);
    end

    // reset_done glitch while locked; relock needs the full sync count.
    cyc(1'b1, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    lock_up();
    cyc(1'b0, 1'b1, 8'h33);
    chk1("locked_dv", data_valid, 1'b1);
    cyc(1'b0, 1'b0, 8'h33);
    chk1("rd_drop_aligned", aligned, 1'b0);
    chk1("rd_drop_dv", data_valid, 1'b0);
    chk8("rd_drop_slide_count", slide_count, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    lock_up();
    chk8("relock_slide_count", slide_count, 8'h00);

    // Sync every 15 bytes never locks and never slides.
    cyc(1'b1, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 200; k++) begin
      cyc(1'b0, 1'b1, (k % 15 == 0) ? 8'hBC : 8'h20);
      chk1("p15_aligned", aligned, 1'b0);
      chk1("p15_rx_slide", rx_slide, 1'b0);
    end

    // First slide timing, then reset just after a pulse abandons the sequence.
    cyc(1'b1, 1'b1, 8'h55);
    for (int i = 1; i <= 18; i++) begin
      cyc(1'b0, 1'b1, 8'h55);
      chk1("first_slide", rx_slide, i == 18);
    end
    cyc(1'b1, 1'b1, 8'h55);
    check_reset_outputs();
    for (int i = 1; i <= 18; i++) begin
      cyc(1'b0, 1'b1, 8'h55);
      chk1("post_rst_slide", rx_slide, i == 18);
    end
    chk8("post_rst_count", slide_count, 8'h01);

    // Continuous 0x55: exact 49-cycle spacing and slide_count wrap.
    cyc(1'b1, 1'b1, 8'h55);
    exact_gap = 1'b1;
    for (int i = 0; i < 13000 && n_pulse < 258; i++) begin
      cyc(1'b0, 1'b1, 8'h55);
    end
    chk_int("pulse_total", n_pulse, 258);
    chk8("wrapped_count", slide_count, 8'h02);
    chk1("never_aligned", aligned, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
